// File: rtl/dma_rd_arb.sv
// dma_rd_arb: three-source round-robin arbiter for a shared DMA read request
// channel, with a tag FIFO that steers multi-beat read responses back to the
// source that issued the request.
// Optional feature: define DMA_RD_ARB_CREDIT_EN to cap outstanding requests
// per source at CREDIT; without it only TAG_DEPTH bounds outstanding requests.
module dma_rd_arb #(
  parameter int REQ_PD_W  = 79,
  parameter int RSP_PD_W  = 514,
  parameter int SIZE_W    = 15,
  parameter int TAG_DEPTH = 16,
  parameter int CREDIT    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              src_req_valid,
  output logic [2:0]              src_req_ready,
  input  logic [3*REQ_PD_W-1:0]   src_req_pd,
  output logic                    rd_req_valid,
  input  logic                    rd_req_ready,
  output logic [REQ_PD_W-1:0]     rd_req_pd,
  output logic [1:0]              wt_dma_id,
  input  logic                    rd_rsp_valid,
  output logic                    rd_rsp_ready,
  input  logic [RSP_PD_W-1:0]     rd_rsp_pd,
  output logic [2:0]              src_rsp_valid,
  input  logic [2:0]              src_rsp_ready,
  output logic [RSP_PD_W-1:0]     src_rsp_pd,
  output logic                    err_unexp_rsp
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  // Reject configurations the pointer arithmetic cannot handle.
  if ((TAG_DEPTH < 2) || ((TAG_DEPTH & (TAG_DEPTH - 1)) != 0) || (CREDIT < 1)) begin : g_bad_cfg
    $error("dma_rd_arb: TAG_DEPTH must be a power of 2 >= 2 and CREDIT >= 1");
  end

  logic [1:0]          tagSrcMem  [TAG_DEPTH];
  logic [SIZE_W-1:0]   tagSizeMem [TAG_DEPTH];
  logic [AW-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SIZE_W-1:0]   beat_q, beat_d;
  logic [1:0]          ptr_q, ptr_d;
  logic                reqValid_q, reqValid_d;
  logic [REQ_PD_W-1:0] reqPd_q, reqPd_d;
  logic [1:0]          dmaId_q, dmaId_d;
  logic                err_q, err_d;

  logic                fifoEmpty, fifoFull, live, canAccept, accept, beat, pop;
  logic [2:0]          eligible, grant, cand;
  logic [1:0]          grantIdx, headSrc;
  logic [SIZE_W-1:0]   headSize;
  logic [REQ_PD_W-1:0] selPd;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CW'(TAG_DEPTH));
  assign headSrc   = tagSrcMem[rdPtr_q];
  assign headSize  = tagSizeMem[rdPtr_q];
  assign live      = !rst && !fifoEmpty;

`ifdef DMA_RD_ARB_CREDIT_EN
  localparam int CRW = $clog2(CREDIT + 1);
  logic [CRW-1:0] credit_q [3];
  logic [CRW-1:0] credit_d [3];

  // A source with CREDIT requests still in flight drops out of arbitration.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 3; i++) begin
      eligible[i] = src_req_valid[i] && (credit_q[i] != CRW'(CREDIT));
    end
  end

  // Per-source outstanding count: +1 on accept, -1 on the final beat of its head tag.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      credit_d[i] = credit_q[i] + CRW'(accept && (grantIdx == 2'(i)))
                                - CRW'(pop && (headSrc == 2'(i)));
    end
  end

  // Credit counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) credit_q[i] <= '0;
      else     credit_q[i] <= credit_d[i];
    end
  end
`else
  assign eligible = src_req_valid;
`endif

  // Round-robin search starting at the priority pointer; grants only when the
  // output register can take a new request and the tag FIFO has room.
  always_comb begin
    grant     = '0;
    grantIdx  = '0;
    accept    = 1'b0;
    cand      = '0;
    canAccept = !rst && (!reqValid_q || rd_req_ready) && !fifoFull;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!accept && canAccept && eligible[cand[1:0]]) begin
        accept   = 1'b1;
        grantIdx = cand[1:0];
      end
    end
    if (accept) grant[grantIdx] = 1'b1;
    selPd = src_req_pd[int'(grantIdx)*REQ_PD_W +: REQ_PD_W];
  end

  // Response steering: only the head-tag source sees the shared response.
  always_comb begin
    src_rsp_valid = '0;
    if (live) src_rsp_valid[headSrc] = rd_rsp_valid;
  end

  assign rd_rsp_ready = live && src_rsp_ready[headSrc];
  assign src_rsp_pd   = rd_rsp_pd;
  assign beat         = rd_rsp_valid && rd_rsp_ready;
  assign pop          = beat && (beat_q == headSize);

  // Tag FIFO pointers, occupancy and beat counter for the head entry.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    beat_d  = beat_q;
    if (beat) begin
      if (pop) begin
        rdPtr_d = rdPtr_q + AW'(1);
        beat_d  = '0;
      end else begin
        beat_d  = beat_q + SIZE_W'(1);
      end
    end
    if (accept) wrPtr_d = wrPtr_q + AW'(1);
    count_d = count_q + CW'(accept) - CW'(pop);
    err_d   = err_q || (fifoEmpty && rd_rsp_valid);
  end

  // Output request register: load on accept, empty once the consumer takes it.
  always_comb begin
    reqValid_d = reqValid_q;
    reqPd_d    = reqPd_q;
    dmaId_d    = dmaId_q;
    ptr_d      = ptr_q;
    if (accept) begin
      reqValid_d = 1'b1;
      reqPd_d    = selPd;
      dmaId_d    = grantIdx;
      ptr_d      = (grantIdx == 2'd2) ? 2'd0 : grantIdx + 2'd1;
    end else if (rd_req_ready) begin
      reqValid_d = 1'b0;
    end
  end

  // Control state, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      ptr_q      <= '0;
      reqValid_q <= 1'b0;
      reqPd_q    <= '0;
      dmaId_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      ptr_q      <= ptr_d;
      reqValid_q <= reqValid_d;
      reqPd_q    <= reqPd_d;
      dmaId_q    <= dmaId_d;
      err_q      <= err_d;
    end
  end

  // Tag storage; contents are meaningless until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      tagSrcMem[wrPtr_q]  <= grantIdx;
      tagSizeMem[wrPtr_q] <= selPd[REQ_PD_W-1 -: SIZE_W];
    end
  end

  assign src_req_ready = grant;
  assign rd_req_valid  = reqValid_q;
  assign rd_req_pd     = reqPd_q;
  assign wt_dma_id     = dmaId_q;
  assign err_unexp_rsp = err_q;

endmodule

// File: tb/tb_dma_rd_arb.sv
// tb_dma_rd_arb: directed scenarios plus a randomized phase for dma_rd_arb,
// checked every cycle against a queue-based reference model.
module tb_dma_rd_arb;

  localparam int REQ_PD_W  = 79;
  localparam int RSP_PD_W  = 514;
  localparam int SIZE_W    = 15;
  localparam int TAG_DEPTH = 16;
  localparam int CREDIT    = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [2:0]            src_req_valid, src_req_ready;
  logic [3*REQ_PD_W-1:0] src_req_pd;
  logic                  rd_req_valid, rd_req_ready;
  logic [REQ_PD_W-1:0]   rd_req_pd;
  logic [1:0]            wt_dma_id;
  logic                  rd_rsp_valid, rd_rsp_ready;
  logic [RSP_PD_W-1:0]   rd_rsp_pd;
  logic [2:0]            src_rsp_valid, src_rsp_ready;
  logic [RSP_PD_W-1:0]   src_rsp_pd;
  logic                  err_unexp_rsp;

  dma_rd_arb #(
    .REQ_PD_W(REQ_PD_W), .RSP_PD_W(RSP_PD_W), .SIZE_W(SIZE_W),
    .TAG_DEPTH(TAG_DEPTH), .CREDIT(CREDIT)
  ) dut (
    .clk(clk), .rst(rst),
    .src_req_valid(src_req_valid), .src_req_ready(src_req_ready), .src_req_pd(src_req_pd),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_pd(rd_req_pd),
    .wt_dma_id(wt_dma_id),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_pd(rd_rsp_pd),
    .src_rsp_valid(src_rsp_valid), .src_rsp_ready(src_rsp_ready), .src_rsp_pd(src_rsp_pd),
    .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  typedef struct { int src; int size; } tag_t;

  // Reference model: outstanding requests as a queue, plus the expected
  // contents of the output request register.
  tag_t                tagQ[$];
  bit                  mValid;
  logic [REQ_PD_W-1:0] mPd;
  int                  mId, mPtr, mBeat;
  bit                  mErr;
  int                  mCred[3];
  int                  errors = 0;
  int                  checks = 0;
  logic [REQ_PD_W-1:0] stallPd;

  task automatic checkOutput(input string tag, input logic [RSP_PD_W-1:0] obs,
                             input logic [RSP_PD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit eligible(input int s);
`ifdef DMA_RD_ARB_CREDIT_EN
    return mCred[s] < CREDIT;
`else
    return s >= 0;
`endif
  endfunction

  function automatic void modelReset();
    tagQ.delete();
    mValid = 0; mPd = '0; mId = 0; mPtr = 0; mBeat = 0; mErr = 0;
    for (int i = 0; i < 3; i++) mCred[i] = 0;
  endfunction

  task automatic setPd(input int src, input int size);
    src_req_pd[src*REQ_PD_W +: REQ_PD_W] = {SIZE_W'(size), $urandom, $urandom};
  endtask

  task automatic driveInputs(input bit rstV, input logic [2:0] valid, input bit rdReady,
                             input bit rspValid, input logic [2:0] srcRspReady);
    rst           = rstV;
    src_req_valid = valid;
    rd_req_ready  = rdReady;
    rd_rsp_valid  = rspValid;
    src_rsp_ready = srcRspReady;
    rd_rsp_pd     = RSP_PD_W'({$urandom, $urandom, $urandom, $urandom});
  endtask

  // One clock cycle: drive, compare against the model, clock, advance the model.
  task automatic applyStimulus(input bit rstV, input logic [2:0] valid, input bit rdReady,
                               input bit rspValid, input logic [2:0] srcRspReady);
    bit         acc, liveRsp, expRspR, wasEmpty;
    int         g, h;
    logic [2:0] expReady, expRspV;
    driveInputs(rstV, valid, rdReady, rspValid, srcRspReady);
    #1;
    acc = !rstV && (!mValid || rdReady) && (tagQ.size() < TAG_DEPTH);
    g = -1;
    if (acc) begin
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && valid[(mPtr + k) % 3] && eligible((mPtr + k) % 3)) g = (mPtr + k) % 3;
      end
    end
    expReady = (g >= 0) ? 3'(1 << g) : 3'b000;
    wasEmpty = (tagQ.size() == 0);
    liveRsp  = !rstV && !wasEmpty;
    h        = liveRsp ? tagQ[0].src : 0;
    expRspV  = (liveRsp && rspValid) ? 3'(1 << h) : 3'b000;
    expRspR  = liveRsp && srcRspReady[h];

    checkOutput("rd_req_valid", RSP_PD_W'(rd_req_valid), RSP_PD_W'(mValid));
    if (mValid) begin
      checkOutput("rd_req_pd", RSP_PD_W'(rd_req_pd), RSP_PD_W'(mPd));
      checkOutput("wt_dma_id", RSP_PD_W'(wt_dma_id), RSP_PD_W'(mId));
    end
    checkOutput("src_req_ready", RSP_PD_W'(src_req_ready), RSP_PD_W'(expReady));
    checkOutput("src_rsp_valid", RSP_PD_W'(src_rsp_valid), RSP_PD_W'(expRspV));
    checkOutput("rd_rsp_ready", RSP_PD_W'(rd_rsp_ready), RSP_PD_W'(expRspR));
    if (liveRsp && rspValid) checkOutput("src_rsp_pd", src_rsp_pd, rd_rsp_pd);
    checkOutput("err_unexp_rsp", RSP_PD_W'(err_unexp_rsp), RSP_PD_W'(mErr));

    @(posedge clk);
    if (rstV) begin
      modelReset();
    end else begin
      if (rspValid && expRspR) begin
        if (mBeat == tagQ[0].size) begin
          mCred[tagQ[0].src]--;
          void'(tagQ.pop_front());
          mBeat = 0;
        end else begin
          mBeat++;
        end
      end
      if (g >= 0) begin
        mPd = src_req_pd[g*REQ_PD_W +: REQ_PD_W];
        tagQ.push_back('{src: g, size: int'(mPd[REQ_PD_W-1 -: SIZE_W])});
        mValid = 1; mId = g; mPtr = (g + 1) % 3;
        mCred[g]++;
      end else if (rdReady) begin
        mValid = 0;
      end
      if (wasEmpty && rspValid) mErr = 1;
    end
    @(negedge clk);
  endtask

  task automatic checkResetState();
    checkOutput("rst_rd_req_valid", RSP_PD_W'(rd_req_valid), '0);
    checkOutput("rst_rd_req_pd", RSP_PD_W'(rd_req_pd), '0);
    checkOutput("rst_wt_dma_id", RSP_PD_W'(wt_dma_id), '0);
    checkOutput("rst_src_req_ready", RSP_PD_W'(src_req_ready), '0);
    checkOutput("rst_err", RSP_PD_W'(err_unexp_rsp), '0);
    checkOutput("rst_rd_rsp_ready", RSP_PD_W'(rd_rsp_ready), '0);
    checkOutput("rst_src_rsp_valid", RSP_PD_W'(src_rsp_valid), '0);
  endtask

  initial begin
    rst = 1'b1; src_req_valid = '0; src_req_pd = '0; rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0; rd_rsp_pd = '0; src_rsp_ready = '0;
    modelReset();
    @(negedge clk);

    $display("[TB] reset values");
    applyStimulus(1, 3'b111, 1, 0, 3'b000);
    applyStimulus(1, 3'b000, 1, 1, 3'b111);
    checkResetState();

    $display("[TB] unexpected response with empty tag FIFO");
    for (int i = 0; i < 3; i++) applyStimulus(0, 3'b000, 1, 1, 3'b111);
    for (int i = 0; i < 2; i++) applyStimulus(0, 3'b000, 1, 0, 3'b111);
    checkOutput("err_sticky", RSP_PD_W'(err_unexp_rsp), RSP_PD_W'(1));
    applyStimulus(1, 3'b000, 1, 0, 3'b111);
    checkOutput("err_cleared", RSP_PD_W'(err_unexp_rsp), '0);

    $display("[TB] round-robin with all sources valid");
    for (int s = 0; s < 3; s++) setPd(s, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 3'b111, 1, 0, 3'b111);
      checkOutput("rr_seq", RSP_PD_W'(wt_dma_id), RSP_PD_W'(k % 3));
    end
    for (int k = 0; k < 10; k++) applyStimulus(0, 3'b000, 1, tagQ.size() > 0, 3'b111);

    $display("[TB] multi-beat response routing");
    setPd(1, 3);
    applyStimulus(0, 3'b010, 1, 0, 3'b111);
    setPd(0, 0);
    applyStimulus(0, 3'b001, 1, 0, 3'b111);
    for (int b = 0; b < 5; b++) begin
      driveInputs(0, 3'b000, 1, 1, 3'b111);
      #1;
      checkOutput("rsp_route", RSP_PD_W'(src_rsp_valid), RSP_PD_W'((b < 4) ? 3'b010 : 3'b001));
      applyStimulus(0, 3'b000, 1, 1, 3'b111);
    end
    driveInputs(0, 3'b000, 1, 0, 3'b111);
    #1;
    checkOutput("rsp_fifo_empty", RSP_PD_W'(rd_rsp_ready), '0);
    applyStimulus(0, 3'b000, 1, 0, 3'b111);

    $display("[TB] output stall then tag FIFO fill");
    setPd(0, 0);
    stallPd = src_req_pd[REQ_PD_W-1:0];
    applyStimulus(0, 3'b001, 0, 0, 3'b111);
    for (int k = 0; k < 10; k++) begin
      driveInputs(0, 3'b001, 0, 0, 3'b111);
      #1;
      checkOutput("stall_ready", RSP_PD_W'(src_req_ready), '0);
      checkOutput("stall_pd", RSP_PD_W'(rd_req_pd), RSP_PD_W'(stallPd));
      applyStimulus(0, 3'b001, 0, 0, 3'b111);
    end
    for (int k = 0; k < 20; k++) applyStimulus(0, 3'b001, 1, 0, 3'b111);
    driveInputs(0, 3'b001, 1, 1, 3'b111);
    #1;
    checkOutput("full_pop_block", RSP_PD_W'(src_req_ready), '0);
    applyStimulus(0, 3'b001, 1, 1, 3'b111);
    driveInputs(0, 3'b001, 1, 0, 3'b111);
    #1;
    checkOutput("after_pop_accept", RSP_PD_W'(src_req_ready), RSP_PD_W'(3'b001));
    applyStimulus(0, 3'b001, 1, 0, 3'b111);
    for (int k = 0; k < 24; k++) applyStimulus(0, 3'b000, 1, tagQ.size() > 0, 3'b111);

    $display("[TB] reset mid-burst");
    for (int s = 0; s < 3; s++) setPd(s, 2);
    for (int k = 0; k < 3; k++) applyStimulus(0, 3'b111, 1, 0, 3'b111);
    applyStimulus(0, 3'b000, 1, 1, 3'b111);
    applyStimulus(1, 3'b000, 1, 1, 3'b111);
    checkResetState();
    setPd(0, 0);
    driveInputs(0, 3'b001, 1, 0, 3'b111);
    #1;
    checkOutput("post_rst_accept", RSP_PD_W'(src_req_ready), RSP_PD_W'(3'b001));
    applyStimulus(0, 3'b001, 1, 0, 3'b111);
    for (int k = 0; k < 4; k++) applyStimulus(0, 3'b000, 1, tagQ.size() > 0, 3'b111);

`ifdef DMA_RD_ARB_CREDIT_EN
    $display("[TB] per-source credit limit");
    applyStimulus(1, 3'b000, 1, 0, 3'b111);
    setPd(0, 0);
    for (int k = 0; k < 10; k++) applyStimulus(0, 3'b001, 1, 0, 3'b111);
    driveInputs(0, 3'b001, 1, 0, 3'b111);
    #1;
    checkOutput("cred_block", RSP_PD_W'(src_req_ready), '0);
    applyStimulus(0, 3'b001, 1, 0, 3'b111);
    setPd(2, 0);
    driveInputs(0, 3'b101, 1, 0, 3'b111);
    #1;
    checkOutput("cred_wgs", RSP_PD_W'(src_req_ready), RSP_PD_W'(3'b100));
    applyStimulus(0, 3'b101, 1, 0, 3'b111);
    applyStimulus(1, 3'b000, 1, 0, 3'b111);
`endif

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      for (int s = 0; s < 3; s++) setPd(s, $urandom_range(0, 3));
      applyStimulus($urandom_range(0, 99) == 0, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0,
                    (tagQ.size() > 0) && ($urandom_range(0, 2) != 0),
                    3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_rd_arb.md
DMA_RD_ARB -- requirements
Module: dma_rd_arb

Interface
REQ-001 SHALL have parameter REQ_PD_W, 79, read request payload width.
REQ-002 SHALL have parameter RSP_PD_W, 514, read response payload width.
REQ-003 SHALL have parameter SIZE_W, 15, size field width at req pd[REQ_PD_W-1 -: SIZE_W]; beats per request = size+1.
REQ-004 SHALL have parameter TAG_DEPTH, 16, outstanding-request tag FIFO depth (power of 2).
REQ-005 SHALL have parameter CREDIT, 8, per-source outstanding limit (used only under REQ-029).
REQ-006 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-008 SHALL have port src_req_valid  in  3  per-source request valid; index 0=WT, 1=WMB, 2=WGS.
REQ-009 SHALL have port src_req_ready  out  3  per-source request accept.
REQ-010 SHALL have port src_req_pd  in  3*REQ_PD_W  source i payload at [i*REQ_PD_W +: REQ_PD_W].
REQ-011 SHALL have ports rd_req_valid out 1, rd_req_ready in 1, rd_req_pd out REQ_PD_W  shared DMA read request channel.
REQ-012 SHALL have port wt_dma_id  out  2  source of current rd_req_pd (2'b00 WT, 2'b01 WMB, 2'b10 WGS).
REQ-013 SHALL have ports rd_rsp_valid in 1, rd_rsp_ready out 1, rd_rsp_pd in RSP_PD_W  shared DMA read response channel.
REQ-014 SHALL have ports src_rsp_valid out 3, src_rsp_ready in 3, src_rsp_pd out RSP_PD_W  per-source response.
REQ-015 SHALL have port err_unexp_rsp  out  1  sticky: rd_rsp_valid seen with tag FIFO empty.

Function
REQ-016 SHALL use valid/ready handshake: transfer when valid&&ready on a rising edge; rd_req_valid/pd/wt_dma_id held stable until transfer.
REQ-017 SHALL register rd_req_* outputs: source accepted in cycle N appears on rd_req_valid in cycle N+1 (latency 1).
REQ-018 SHALL accept a request only when output stage free (!rd_req_valid || rd_req_ready) and tag FIFO not full; at most one src_req_ready bit high per cycle.
REQ-019 SHALL arbitrate round-robin over eligible valid sources: priority pointer resets to 0; after grant to i pointer = (i+1) mod 3; no grant leaves pointer unchanged.
REQ-020 SHALL push {source id, size} into tag FIFO on each accept; full = TAG_DEPTH entries, push at full blocked even if pop same cycle.
REQ-021 SHALL route responses combinationally (0 latency) to head-tag source h: src_rsp_valid[h]=rd_rsp_valid, src_rsp_pd=rd_rsp_pd, rd_rsp_ready=src_rsp_ready[h]; other src_rsp_valid bits 0.
REQ-022 SHALL count response beats of head entry with beat counter (SIZE_W bits, reset 0): on beat transfer, if counter==head size then pop FIFO and clear counter, else increment.
REQ-023 SHALL, with tag FIFO empty, drive rd_rsp_ready=0 and src_rsp_valid=0; rd_rsp_valid high in that state sets err_unexp_rsp until reset.
REQ-024 SHALL support simultaneous accept (push) and final-beat pop in one cycle with count unchanged.
REQ-025 SHALL, with a stalled output stage (rd_req_valid && !rd_req_ready), deassert all src_req_ready and hold arbitration pointer.

Reset
REQ-026 SHALL on rst=1 clear: rd_req_valid=0, rd_req_pd=0, wt_dma_id=0, src_req_ready=0, tag FIFO empty, beat counter 0, pointer 0, err_unexp_rsp=0, credit counters 0.
REQ-027 SHALL on rst mid-operation discard all outstanding tags and in-flight request; first accept possible cycle after rst deasserts.
REQ-028 SHALL hold rd_rsp_ready=0 and src_rsp_valid=0 while rst=1.

Configuration
REQ-029 SHALL, when DMA_RD_ARB_CREDIT_EN is defined, keep a per-source outstanding counter (+1 on accept, -1 on final-beat pop, both same cycle = unchanged) and make source ineligible when counter==CREDIT; when undefined, no per-source limit, only TAG_DEPTH bounds outstanding requests.

Verification
REQ-030 SHALL cover: all 3 sources valid continuously, rd_req_ready=1 -> wt_dma_id sequence 0,1,2,0,1,2, one request per cycle.
REQ-031 SHALL cover: WMB req size=3 then WT req size=0, responses 5 beats -> 4 beats to src 1 then 1 beat to src 0, FIFO empty after.
REQ-032 SHALL cover: rd_req_ready=0 for 10 cycles with src 0 valid -> rd_req_pd stable, src_req_ready=0, 16 requests then fill FIFO and block the 17th until first final beat.
REQ-033 SHALL cover: rd_rsp_valid=1 after reset with no requests -> rd_rsp_ready=0, err_unexp_rsp=1 next cycle and sticky.
REQ-034 SHALL cover: DMA_RD_ARB_CREDIT_EN, CREDIT=8, only WT valid, no responses -> 8 accepts then WT blocked; WGS still granted.
REQ-035 SHALL cover: rst asserted with 3 outstanding tags mid-burst -> all outputs at REQ-026 values next cycle, new request accepted after release.
